// File: rtl/sliding_window_pkg.sv
// rtl/sliding_window_pkg.sv - shared defaults and index helpers for sliding_window_gen
//
// Purpose : default parameter values, coordinate width helper and the flat
//           window bus index helper shared by the window generator files.
// Ports   : none (package).
package sliding_window_pkg;

    localparam int DEF_PIXEL_WIDTH = 30;
    localparam int DEF_WIN_W       = 9;
    localparam int DEF_WIN_H       = 9;
    localparam int DEF_IMG_W       = 28;
    localparam int DEF_IMG_H       = 28;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of window element (r, c) on the flat out_window bus.
    function automatic int win_idx(input int r, input int c, input int win_w, input int pix_w);
        return (r * win_w + c) * pix_w;
    endfunction

endpackage

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - one image-row delay line for the window generator
//
// Purpose : circular RAM IMG_W pixels deep. The address is the shared column
//           counter, so the word read at addr is the pixel written exactly one
//           row earlier at the same column; it is then overwritten with din.
// Ports   : clock  - rising-edge clock
//           wr_en  - advance (pixel accepted this cycle)
//           addr   - current column
//           din    - pixel entering this row delay
//           dout   - same-column pixel from the previous row
module window_line_buffer
    import sliding_window_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int ADDR_W      = coord_width(IMG_W)
) (
    input  logic                   clock,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [PIXEL_WIDTH-1:0] din,
    output logic [PIXEL_WIDTH-1:0] dout
);

    logic [PIXEL_WIDTH-1:0] mem [IMG_W];

    // Read-before-write: the tap is the old contents of the slot being refilled.
    assign dout = mem[addr];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/sliding_window_gen.sv
// rtl/sliding_window_gen.sv - raster pixel stream to WIN_H x WIN_W window stream
//
// Purpose : takes a raster-order pixel stream, keeps WIN_H-1 rows in line
//           buffers and emits every fully populated window with its image
//           coordinate, behind a one-deep output register.
// Ports   : clock, reset        - rising-edge clock, synchronous active-high reset
//           in_valid/in_ready   - pixel handshake, in_pixel is the pixel
//           out_valid/out_ready - window handshake
//           out_window          - element (r,c) at [(r*WIN_W+c)*PIXEL_WIDTH +: PIXEL_WIDTH]
//           out_row/out_col     - image coordinate of element (WIN_H-1, WIN_W-1)
//           frame_done          - one-cycle pulse after the last pixel of a frame
module sliding_window_gen
    import sliding_window_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int WIN_H       = DEF_WIN_H,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PIXEL_WIDTH-1:0]             in_pixel,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIN_W*WIN_H*PIXEL_WIDTH-1:0] out_window,
    output logic [coord_width(IMG_H)-1:0]      out_row,
    output logic [coord_width(IMG_W)-1:0]      out_col,
    output logic                               frame_done
);

    localparam int ROW_W = coord_width(IMG_H);
    localparam int COL_W = coord_width(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             accept;
    logic             qualify;
    logic             last_pixel;

    logic [PIXEL_WIDTH-1:0] tap      [WIN_H-1];
    logic [PIXEL_WIDTH-1:0] new_col  [WIN_H];
    logic [PIXEL_WIDTH-1:0] win      [WIN_H][WIN_W];
    logic [PIXEL_WIDTH-1:0] win_next [WIN_H][WIN_W];

    // The output register may only be overwritten once its window is taken.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
    // Windows that would straddle a row wrap or reach above row 0 are dropped;
    // this also keeps stale line-buffer/window contents from ever being emitted.
    assign qualify    = (int'(row) >= WIN_H - 1) && (int'(col) >= WIN_W - 1);

    // Line buffer chain: tap[k] is the pixel from row-1-k at the current column.
    for (genvar k = 0; k < WIN_H - 1; k++) begin : g_lb
        logic [PIXEL_WIDTH-1:0] lb_din;
        if (k == 0) begin : g_first
            assign lb_din = in_pixel;
        end else begin : g_rest
            assign lb_din = tap[k-1];
        end
        window_line_buffer #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .IMG_W       (IMG_W),
            .ADDR_W      (COL_W)
        ) u_line_buffer (
            .clock (clock),
            .wr_en (accept),
            .addr  (col),
            .din   (lb_din),
            .dout  (tap[k])
        );
    end

    // Incoming column, top (oldest row) first; the live pixel is the bottom row.
    always_comb begin
        for (int r = 0; r < WIN_H; r++) begin
            new_col[r] = '0;
        end
        new_col[WIN_H-1] = in_pixel;
        for (int k = 0; k < WIN_H - 1; k++) begin
            new_col[WIN_H-2-k] = tap[k];
        end
    end

    // Window after this accept: shift left one column, append new_col.
    always_comb begin
        for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W - 1; c++) begin
                win_next[r][c] = win[r][c+1];
            end
            win_next[r][WIN_W-1] = new_col[r];
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            win <= win_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            frame_done <= accept && last_pixel;
            if (accept && qualify) begin
                out_valid <= 1'b1;
                out_row   <= row;
                out_col   <= col;
                for (int r = 0; r < WIN_H; r++) begin
                    for (int c = 0; c < WIN_W; c++) begin
                        out_window[win_idx(r, c, WIN_W, PIXEL_WIDTH) +: PIXEL_WIDTH] <= win_next[r][c];
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
